// File: rtl/csa_pkg.sv
// Shared types and defaults for the carry-save resolver.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } csa_res_state_t;

    localparam int CSA_CHUNK_DEFAULT = 8;

endpackage

// File: rtl/csa_chunk_adder.sv
// One CHUNK_WIDTH-bit slice of the resolver's ripple addition.
module csa_chunk_adder
    import csa_pkg::*;
#(
    parameter int CHUNK_WIDTH = CSA_CHUNK_DEFAULT
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] s,
    output logic                   cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + (CHUNK_WIDTH + 1)'(cin);

endmodule

// File: rtl/csa_resolver.sv
// Iterative carry-save to binary resolver, CHUNK_WIDTH bits per cycle.
// Optional early exit on a quiet upper carry vector: CSA_RESOLVER_EARLY_EXIT_EN.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int CHUNK_WIDTH = CSA_CHUNK_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] sum_in,
    input  logic [BIT_WIDTH-1:0] carry_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 carry_out
);

    localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    csa_res_state_t       state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 cc_q, cc_d;
    logic [BIT_WIDTH-1:0] op_sum_q, op_sum_d;
    logic [BIT_WIDTH-1:0] op_carry_q, op_carry_d;
    logic [BIT_WIDTH-1:0] result_q, result_d;
    logic                 cout_q, cout_d;

    logic [CHUNK_WIDTH-1:0] chunk_a, chunk_b, chunk_s;
    logic                   chunk_c;

    assign chunk_a = op_sum_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign chunk_b = op_carry_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];

    csa_chunk_adder #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk_adder (
        .a   (chunk_a),
        .b   (chunk_b),
        .cin (cc_q),
        .s   (chunk_s),
        .cout(chunk_c)
    );

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
    // Bits above the chunk being written this cycle.
    int                   hi_shift;
    logic [BIT_WIDTH-1:0] hi_mask;
    logic                 upper_quiet;

    assign hi_shift    = (int'(idx_q) + 1) * CHUNK_WIDTH;
    assign hi_mask     = {BIT_WIDTH{1'b1}} << hi_shift;
    assign upper_quiet = ((op_carry_q & hi_mask) == '0);
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cc_d       = cc_q;
        op_sum_d   = op_sum_q;
        op_carry_d = op_carry_q;
        result_d   = result_q;
        cout_d     = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_sum_d   = sum_in;
                    op_carry_d = carry_in;
                    idx_d      = '0;
                    cc_d       = 1'b0;
                    result_d   = '0;
                    cout_d     = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                result_d[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_s;
                cc_d  = chunk_c;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_c;
                    state_d = DONE;
                end
`ifdef CSA_RESOLVER_EARLY_EXIT_EN
                else if (!chunk_c && upper_quiet) begin
                    // No carry can enter the upper chunks, so they equal sum_in.
                    result_d = (result_d & ~hi_mask) | (op_sum_q & hi_mask);
                    cout_d   = 1'b0;
                    state_d  = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cc_q       <= 1'b0;
            op_sum_q   <= '0;
            op_carry_q <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cc_q       <= cc_d;
            op_sum_q   <= op_sum_d;
            op_carry_q <= op_carry_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;

endmodule
